// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: loadable instruction memory, register file,
// ALU with carry/zero flags, fetch/execute FSM and a valid/ready result port.
module cpu_core_param #(
    parameter int  DATA_W     = 8,
    parameter int  NREGS      = 4,
    parameter int  IMEM_DEPTH = 16,
    localparam int RA_W       = $clog2(NREGS),
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int INSTR_W    = 4 + 2 * RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic               carry_flag,
    output logic               zero_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_r;
    logic [INSTR_W-1:0] ir_r;
    logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];
    logic [DATA_W-1:0]  regs_r [NREGS];
    logic [PC_W-1:0]    pc_r;
    logic               c_r;
    logic               z_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               halted_r;

    logic [3:0]         opcode_s;
    logic [RA_W-1:0]    rd_s;
    logic [RA_W-1:0]    rs_s;
    logic [DATA_W-1:0]  imm_s;
    logic [DATA_W-1:0]  a_s;
    logic [DATA_W-1:0]  b_s;
    logic [DATA_W-1:0]  res_s;
    logic               c_s;
    logic               wr_s;
    logic [PC_W-1:0]    pc_inc_s;
    logic               idle_s;

    assign opcode_s = ir_r[INSTR_W-1 -: 4];
    assign rd_s     = ir_r[2*RA_W+DATA_W-1 -: RA_W];
    assign rs_s     = ir_r[RA_W+DATA_W-1 -: RA_W];
    assign imm_s    = ir_r[DATA_W-1:0];
    assign a_s      = regs_r[rd_s];
    assign b_s      = regs_r[rs_s];
    assign pc_inc_s = pc_r + PC_W'(1);
    assign idle_s   = (state_r == S_IDLE) || (state_r == S_HALT);

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign pc         = pc_r;
    assign carry_flag = c_r;
    assign zero_flag  = z_r;

    // Instruction memory write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (!rst && load_en && idle_s) begin
            imem_r[load_addr] <= load_data;
        end
    end

    // ALU: result, carry and register write-enable for opcodes 1..A.
    always_comb begin
        res_s = {DATA_W{1'b0}};
        c_s   = c_r;
        wr_s  = 1'b0;
        case (opcode_s)
            OP_ADD: begin {c_s, res_s} = {1'b0, a_s} + {1'b0, b_s}; wr_s = 1'b1; end
            OP_SUB: begin {c_s, res_s} = {1'b0, a_s} - {1'b0, b_s}; wr_s = 1'b1; end
            OP_AND: begin res_s = a_s & b_s; c_s = 1'b0; wr_s = 1'b1; end
            OP_OR:  begin res_s = a_s | b_s; c_s = 1'b0; wr_s = 1'b1; end
            OP_XOR: begin res_s = a_s ^ b_s; c_s = 1'b0; wr_s = 1'b1; end
            OP_NOT: begin res_s = ~b_s;      c_s = 1'b0; wr_s = 1'b1; end
            OP_SHL: begin res_s = {b_s[DATA_W-2:0], 1'b0}; c_s = b_s[DATA_W-1]; wr_s = 1'b1; end
            OP_SHR: begin res_s = {1'b0, b_s[DATA_W-1:1]}; c_s = b_s[0];        wr_s = 1'b1; end
            OP_LDI: begin res_s = imm_s; wr_s = 1'b1; end
            OP_MOV: begin res_s = b_s;   wr_s = 1'b1; end
            default: begin
                res_s = {DATA_W{1'b0}};
                c_s   = c_r;
                wr_s  = 1'b0;
            end
        endcase
    end

    // Fetch/execute FSM with all architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ir_r        <= {INSTR_W{1'b0}};
            pc_r        <= {PC_W{1'b0}};
            c_r         <= 1'b0;
            z_r         <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_r  <= S_FETCH;
                        pc_r     <= {PC_W{1'b0}};
                        c_r      <= 1'b0;
                        z_r      <= 1'b0;
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_r    <= imem_r[pc_r];
                    state_r <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_s) begin
                        regs_r[rd_s] <= res_s;
                        c_r          <= c_s;
                        z_r          <= (res_s == {DATA_W{1'b0}});
                    end
                    case (opcode_s)
                        OP_JMP: begin
                            pc_r    <= imm_s[PC_W-1:0];
                            state_r <= S_FETCH;
                        end
                        OP_JZ: begin
                            pc_r    <= z_r ? imm_s[PC_W-1:0] : pc_inc_s;
                            state_r <= S_FETCH;
                        end
                        OP_JC: begin
                            pc_r    <= c_r ? imm_s[PC_W-1:0] : pc_inc_s;
                            state_r <= S_FETCH;
                        end
                        OP_OUT: begin
                            out_data_r  <= a_s;
                            out_valid_r <= 1'b1;
                            state_r     <= S_OUT_WAIT;
                        end
                        OP_HALT: begin
                            state_r  <= S_HALT;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                        end
                        default: begin
                            pc_r    <= pc_inc_s;
                            state_r <= S_FETCH;
                        end
                    endcase
                end
                S_OUT_WAIT: begin
                    // pc only advances once the consumer has taken the value
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        pc_r        <= pc_inc_s;
                        state_r     <= S_FETCH;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    halted_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed self-checking bench for cpu_core_param: default instance plus a
// DATA_W=16 / NREGS=8 / IMEM_DEPTH=32 instance.
module tb_cpu_core_param;

    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, SHL = 4'h7, SHR = 4'h8,
                           LDI = 4'h9, JMP = 4'hB, JC = 4'hD, OUT = 4'hE, HLT = 4'hF;

    logic        clk = 1'b0;
    logic        rst, start, load_en, out_ready;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [7:0]  out_data;
    logic        out_valid, busy, halted, carry_flag, zero_flag;
    logic [3:0]  pc;

    logic        p_start, p_load_en, p_out_ready;
    logic [4:0]  p_load_addr;
    logic [25:0] p_load_data;
    logic [15:0] p_out_data;
    logic        p_out_valid, p_busy, p_halted, p_carry, p_zero;
    logic [4:0]  p_pc;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  xd [8];
    logic        xc [8];
    logic        xz [8];
    int          xn;
    logic        wrap_seen;
    int          p_xn;
    logic [15:0] p_xd;

    always #5 clk = ~clk;

    cpu_core_param dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .halted(halted),
        .pc(pc), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    cpu_core_param #(.DATA_W(16), .NREGS(8), .IMEM_DEPTH(32)) dut_p (
        .clk(clk), .rst(rst), .start(p_start), .load_en(p_load_en),
        .load_addr(p_load_addr), .load_data(p_load_data), .out_data(p_out_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .busy(p_busy), .halted(p_halted),
        .pc(p_pc), .carry_flag(p_carry), .zero_flag(p_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [25:0] pins(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pload(input logic [4:0] a, input logic [25:0] d);
        p_load_en = 1'b1; p_load_addr = a; p_load_data = d;
        tick();
        p_load_en = 1'b0;
    endtask

    task automatic start_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until halted (bounded), logging each handshake with the flags at that time.
    task automatic run_to_halt(input int maxc);
        logic [3:0] prev;
        xn = 0; wrap_seen = 1'b0; prev = pc;
        for (int i = 0; i < maxc && !halted; i++) begin
            if (out_valid && out_ready && xn < 8) begin
                xd[xn] = out_data; xc[xn] = carry_flag; xz[xn] = zero_flag;
                xn++;
            end
            tick();
            if (prev == 4'hF && pc == 4'h0) wrap_seen = 1'b1;
            prev = pc;
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic wait_valid(input int maxc);
        for (int i = 0; i < maxc && !out_valid; i++) tick();
        chk("valid_seen", out_valid, 1);
    endtask

    task automatic load_prog1();
        load(4'd0, ins(LDI, 2'd0, 2'd0, 8'd5));
        load(4'd1, ins(LDI, 2'd1, 2'd0, 8'd3));
        load(4'd2, ins(ADD, 2'd0, 2'd1, 8'd0));
        load(4'd3, ins(OUT, 2'd0, 2'd0, 8'd0));
        load(4'd4, ins(HLT, 2'd0, 2'd0, 8'd0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = 4'd0; load_data = 16'd0;
        out_ready = 1'b1;
        p_start = 1'b0; p_load_en = 1'b0; p_load_addr = 5'd0; p_load_data = 26'd0;
        p_out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_c", carry_flag, 0);
        chk("rst_z", zero_flag, 0);
        rst = 1'b0;

        // Basic ALU program and OUT latency
        load_prog1();
        start_prog();
        chk("t1_busy", busy, 1);
        repeat (7) tick();
        chk("t1_valid_early", out_valid, 0);
        tick();
        chk("t1_valid_rise", out_valid, 1);
        chk("t1_data", out_data, 8'd8);
        tick();
        chk("t1_valid_drop", out_valid, 0);
        run_to_halt(50);
        chk("t1_extra_xfer", xn, 0);
        chk("t1_pc", pc, 4);
        chk("t1_c", carry_flag, 0);
        chk("t1_z", zero_flag, 0);
        chk("t1_busy_end", busy, 0);

        // Carry/zero and taken JC
        load(4'd0, ins(LDI, 2'd0, 2'd0, 8'hFF));
        load(4'd1, ins(LDI, 2'd1, 2'd0, 8'd1));
        load(4'd2, ins(ADD, 2'd0, 2'd1, 8'd0));
        load(4'd3, ins(JC,  2'd0, 2'd0, 8'd6));
        load(4'd4, ins(OUT, 2'd1, 2'd0, 8'd0));
        load(4'd5, ins(HLT, 2'd0, 2'd0, 8'd0));
        load(4'd6, ins(OUT, 2'd0, 2'd0, 8'd0));
        load(4'd7, ins(HLT, 2'd0, 2'd0, 8'd0));
        start_prog();
        repeat (6) tick();
        chk("t2_add_c", carry_flag, 1);
        chk("t2_add_z", zero_flag, 1);
        run_to_halt(50);
        chk("t2_xfers", xn, 1);
        chk("t2_data", xd[0], 8'h00);
        chk("t2_pc", pc, 7);

        // SUB borrow, SHL, SHR
        load(4'd0, ins(LDI, 2'd0, 2'd0, 8'd2));
        load(4'd1, ins(LDI, 2'd1, 2'd0, 8'd3));
        load(4'd2, ins(SUB, 2'd0, 2'd1, 8'd0));
        load(4'd3, ins(OUT, 2'd0, 2'd0, 8'd0));
        load(4'd4, ins(SHL, 2'd0, 2'd0, 8'd0));
        load(4'd5, ins(OUT, 2'd0, 2'd0, 8'd0));
        load(4'd6, ins(LDI, 2'd2, 2'd0, 8'd1));
        load(4'd7, ins(SHR, 2'd2, 2'd2, 8'd0));
        load(4'd8, ins(OUT, 2'd2, 2'd0, 8'd0));
        load(4'd9, ins(HLT, 2'd0, 2'd0, 8'd0));
        start_prog();
        run_to_halt(80);
        chk("t3_xfers", xn, 3);
        chk("t3_sub_val", xd[0], 8'hFF);
        chk("t3_sub_c", xc[0], 1);
        chk("t3_sub_z", xz[0], 0);
        chk("t3_shl_val", xd[1], 8'hFE);
        chk("t3_shl_c", xc[1], 1);
        chk("t3_shr_val", xd[2], 8'h00);
        chk("t3_shr_c", xc[2], 1);
        chk("t3_shr_z", xz[2], 1);

        // Backpressure: ready low for 5 cycles
        load(4'd0, ins(LDI, 2'd3, 2'd0, 8'hA5));
        load(4'd1, ins(OUT, 2'd3, 2'd0, 8'd0));
        load(4'd2, ins(HLT, 2'd0, 2'd0, 8'd0));
        out_ready = 1'b0;
        start_prog();
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_data_hold", out_data, 8'hA5);
            chk("bp_pc_hold", pc, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_pc_adv", pc, 2);
        run_to_halt(20);
        chk("bp_extra_xfer", xn, 0);

        // PC wrap, load_en ignored while busy, rerun from HALT
        for (int a = 3; a < 14; a++) load(4'(a), ins(NOP, 2'd0, 2'd0, 8'd0));
        load(4'd0,  ins(JC,  2'd0, 2'd0, 8'd2));
        load(4'd1,  ins(JMP, 2'd0, 2'd0, 8'd14));
        load(4'd2,  ins(HLT, 2'd0, 2'd0, 8'd0));
        load(4'd14, ins(LDI, 2'd0, 2'd0, 8'hFF));
        load(4'd15, ins(ADD, 2'd0, 2'd0, 8'd0));
        start_prog();
        repeat (3) tick();
        load_en = 1'b1; load_addr = 4'd2; load_data = ins(NOP, 2'd0, 2'd0, 8'd0);
        tick(); tick();
        load_en = 1'b0;
        run_to_halt(100);
        chk("wrap_pc", pc, 2);
        chk("wrap_seen", wrap_seen, 1);
        start_prog();
        run_to_halt(100);
        chk("rerun_pc", pc, 2);
        chk("rerun_wrap", wrap_seen, 1);

        // Reset in EXEC, then rerun from retained imem
        load_prog1();
        start_prog();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_busy", busy, 0);
        chk("rx_pc", pc, 0);
        chk("rx_valid", out_valid, 0);
        start_prog();
        run_to_halt(50);
        chk("rx_rerun_xfers", xn, 1);
        chk("rx_rerun_data", xd[0], 8'd8);
        chk("rx_rerun_pc", pc, 4);

        // Reset in OUT_WAIT drops valid with no transfer
        out_ready = 1'b0;
        start_prog();
        wait_valid(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ro_valid", out_valid, 0);
        chk("ro_data", out_data, 0);
        chk("ro_busy", busy, 0);
        chk("ro_halted", halted, 0);
        chk("ro_pc", pc, 0);
        out_ready = 1'b1;

        // Registers cleared by reset; load+start together reads the new word at 0
        load(4'd1, ins(OUT, 2'd1, 2'd0, 8'd0));
        load(4'd2, ins(HLT, 2'd0, 2'd0, 8'd0));
        load_en = 1'b1; load_addr = 4'd0; load_data = ins(OUT, 2'd0, 2'd0, 8'd0);
        start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        run_to_halt(50);
        chk("rz_xfers", xn, 2);
        chk("rz_r0", xd[0], 8'd0);
        chk("rz_r1", xd[1], 8'd0);
        chk("rz_pc", pc, 2);

        // Wide instance: 16-bit carry-out and JMP using only low PC bits
        pload(5'd0, pins(LDI, 3'd7, 3'd0, 16'hFFFF));
        pload(5'd1, pins(LDI, 3'd6, 3'd0, 16'h0001));
        pload(5'd2, pins(ADD, 3'd7, 3'd6, 16'h0000));
        pload(5'd3, pins(JMP, 3'd0, 3'd0, 16'h0025));
        pload(5'd4, pins(HLT, 3'd0, 3'd0, 16'h0000));
        pload(5'd5, pins(OUT, 3'd7, 3'd0, 16'h0000));
        pload(5'd6, pins(HLT, 3'd0, 3'd0, 16'h0000));
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        p_xn = 0; p_xd = 16'hDEAD;
        for (int i = 0; i < 60 && !p_halted; i++) begin
            if (p_out_valid && p_out_ready) begin p_xn++; p_xd = p_out_data; end
            tick();
        end
        chk("p_halted", p_halted, 1);
        chk("p_pc", p_pc, 6);
        chk("p_xfers", p_xn, 1);
        chk("p_sum", p_xd, 16'h0000);
        chk("p_c", p_carry, 1);
        chk("p_z", p_zero, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
